// File: rtl/traffic_light_fsm.sv
// -----------------------------------------------------------------------------
// traffic_light_fsm
//
// Main sequencing controller for the intersection. Each phase selects a Timer
// interval, pulses start_timer in its first cycle and waits for expired.
// The side-street sensor and the walk-register status are looked at only in
// the cycle an expiry is accepted.
//
// Handshake with the Timer: start_timer is a one-cycle pulse, and interval is
// valid in that same cycle and held for the rest of the phase. An expired
// pulse is accepted only when start_timer is low. An expired pulse that
// arrives together with start_timer is ignored.
//
// Ports
//   clk          system clock, rising edge
//   sys_reset    synchronous, active-high reset
//   sensor_sync  synchronized side-street vehicle sensor (level)
//   WR           walk-register status, 1 = walk pending
//   expired      Timer expiry pulse
//   start_timer  one-cycle pulse that loads and starts the Timer
//   interval     interval address presented to TimeParameters
//   WR_reset     one-cycle pulse that clears the walk register
//   Rm Ym Gm     main-street lamps
//   Rs Ys Gs     side-street lamps
//   W            walk lamp
//   state_dbg    current FSM state, for observation only
// -----------------------------------------------------------------------------
module traffic_light_fsm (
    input  logic       clk,
    input  logic       sys_reset,
    input  logic       sensor_sync,
    input  logic       WR,
    input  logic       expired,
    output logic       start_timer,
    output logic [1:0] interval,
    output logic       WR_reset,
    output logic       Rm,
    output logic       Ym,
    output logic       Gm,
    output logic       Rs,
    output logic       Ys,
    output logic       Gs,
    output logic       W,
    output logic [2:0] state_dbg
);

    localparam logic [1:0] INT_BASE = 2'b00;
    localparam logic [1:0] INT_EXT  = 2'b01;
    localparam logic [1:0] INT_YEL  = 2'b10;

    typedef enum logic [2:0] {
        S_MG1  = 3'd0,
        S_MG2  = 3'd1,
        S_MY   = 3'd2,
        S_WALK = 3'd3,
        S_SG1  = 3'd4,
        S_SG2  = 3'd5,
        S_SY   = 3'd6
    } state_t;

    // Lamp vector layout: {Rm, Ym, Gm, Rs, Ys, Gs, W}
    localparam logic [6:0] L_MG   = 7'b0011000;
    localparam logic [6:0] L_MY   = 7'b0101000;
    localparam logic [6:0] L_WALK = 7'b1001001;
    localparam logic [6:0] L_SG   = 7'b1000010;
    localparam logic [6:0] L_SY   = 7'b1000100;

    state_t     state;
    state_t     next_state;
    logic       mg2_ext;      // MG2 uses the extended interval
    logic       next_mg2_ext;
    logic       restart;      // high while in reset; starts MG1 after release
    logic       accept;
    logic       go;           // take next_state this edge
    logic [6:0] lamps;

    function automatic logic [1:0] interval_of(input state_t s, input logic ext);
        logic [1:0] r;
        r = INT_BASE;
        case (s)
            S_MG2:  r = ext ? INT_EXT : INT_BASE;
            S_MY:   r = INT_YEL;
            S_WALK: r = INT_EXT;
            S_SG2:  r = INT_EXT;
            S_SY:   r = INT_YEL;
            default: r = INT_BASE;
        endcase
        return r;
    endfunction

    function automatic logic [6:0] lamps_of(input state_t s);
        logic [6:0] r;
        r = L_MG;
        case (s)
            S_MY:   r = L_MY;
            S_WALK: r = L_WALK;
            S_SG1:  r = L_SG;
            S_SG2:  r = L_SG;
            S_SY:   r = L_SY;
            default: r = L_MG;
        endcase
        return r;
    endfunction

    // The first cycle of a phase (start_timer high) never accepts expired,
    // so a late or stretched expiry cannot skip a phase.
    assign accept = expired && !start_timer && !restart;

    always_comb begin
        next_state   = state;
        next_mg2_ext = mg2_ext;
        go           = accept;
        case (state)
            S_MG1: begin
                next_state   = S_MG2;
                next_mg2_ext = sensor_sync;
            end
            S_MG2:  next_state = S_MY;
            S_MY:   next_state = WR ? S_WALK : S_SG1;
            S_WALK: next_state = S_SG1;
            S_SG1:  next_state = sensor_sync ? S_SG2 : S_SY;
            S_SG2:  next_state = S_SY;
            S_SY:   next_state = S_MG1;
            default: begin
                // Unused encoding: restart the cycle at MG1 immediately.
                next_state = S_MG1;
                go         = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (sys_reset) begin
            state       <= S_MG1;
            mg2_ext     <= 1'b0;
            restart     <= 1'b1;
            start_timer <= 1'b0;
            WR_reset    <= 1'b0;
            interval    <= INT_BASE;
            lamps       <= L_MG;
        end else begin
            restart     <= 1'b0;
            start_timer <= go || restart;
            WR_reset    <= go && (next_state == S_WALK);
            if (go) begin
                state    <= next_state;
                mg2_ext  <= next_mg2_ext;
                interval <= interval_of(next_state, next_mg2_ext);
                lamps    <= lamps_of(next_state);
            end
        end
    end

    assign {Rm, Ym, Gm, Rs, Ys, Gs, W} = lamps;
    assign state_dbg = state;

endmodule
